sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Digital responder for the SRAM request interface: it accepts single-word read/write requests from a master (the QRAcc controller) and sequences the analog macro's SRAM controls (PCH, WL, WRITE, CSEL, SAEN, WR_DATA), capturing SA_OUT for reads. It sits between the controller's `sram_itf` master modport and the SRAM portion of the `to_analog_t` / `from_analog_t` bundles. MAC-mode signals (switch matrix, ADC) are outside its scope and are driven elsewhere.

## Interface
- numRows, 128, SRAM rows; power of two; sets addr width clog2(numRows)
- numCols, 32, SRAM word width in bits
- pchCycles, 2, precharge duration in cycles (≥1)
- wlCycles, 2, wordline-on duration before SAEN (read) or with WRITE (write) (≥1)
- saenCycles, 1, sense-amp enable duration in cycles (≥1)

- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- rq_valid_i  in  1  request valid
- rq_wr_i  in  1  1 = write, 0 = read
- addr_i  in  clog2(numRows)  row address
- wr_data_i  in  numCols  write data
- rq_ready_o  out  1  ready to accept a request
- rd_valid_o  out  1  one-cycle pulse; rd_data_o valid
- rd_data_o  out  numCols  read data, held until the next read completes
- WL  out  numRows  one-hot wordline
- PCH  out  1  bitline precharge, active-high
- WRITE  out  1  write-driver enable
- WR_DATA  out  numCols  bitline write data
- CSEL  out  numCols  column select; all-ones during any access
- SAEN  out  1  sense-amp enable
- SA_OUT  in  numCols  sense-amp outputs

## Operation
- FSM states: IDLE, PRECHARGE, WORDLINE, SENSE, DONE. One down-counter, reloaded on each state entry.
- IDLE: rq_ready_o=1. If rq_valid_i=1, accept on the clock edge. Latch addr_i, rq_wr_i and wr_data_i, then go to PRECHARGE. Input changes after acceptance are ignored.
- PRECHARGE: PCH=1 for pchCycles, CSEL=all-ones, WL=0. Then go to WORDLINE.
- WORDLINE: WL[addr]=1 and CSEL=all-ones for wlCycles.
  - Write: WRITE=1 and WR_DATA=latched data throughout. Then go to IDLE.
  - Read: WRITE=0. Then go to SENSE.
- SENSE (read only): WL[addr]=1 and SAEN=1 for saenCycles. On the edge ending the last SENSE cycle, register SA_OUT into rd_data_o. Then go to DONE.
- DONE is a virtual state, merged into IDLE: rd_valid_o=1 for exactly the first IDLE cycle after SENSE. Writes never pulse rd_valid_o.
- While the FSM is busy, rq_ready_o=0 and rq_valid_i is ignored; the master must hold its request.
- Back-to-back: a new request may be accepted in the same cycle rd_valid_o is high.
- WR_DATA holds the last latched write data between writes. WRITE gates its use.

## Timing
- Reset values: rq_ready_o=1, rd_valid_o=0, rd_data_o=0, WL=0, PCH=0, WRITE=0, WR_DATA=0, CSEL=0, SAEN=0, FSM in IDLE.
- All outputs are registered, so the analog controls are glitch-free.
- Accept edge = E0.
  - Read (defaults): PCH high in cycles 1–2, WL in cycles 3–5, SAEN in cycle 5. rd_valid_o and rq_ready_o are high in cycle 6. Read latency = pchCycles+wlCycles+saenCycles+1.
  - Write (defaults): PCH in cycles 1–2, WL+WRITE in cycles 3–4, rq_ready_o high in cycle 5. Write latency = pchCycles+wlCycles+1.
- PCH and WL are never high in the same cycle. WL deasserts in the same cycle SAEN/WRITE deassert.
- Reset mid-operation: on the next edge all analog controls go to 0, rd_valid_o=0, rd_data_o=0, FSM=IDLE. A partial write is discarded and no completion is signalled.
- rst with rq_valid_i high in the same cycle: no acceptance.

## Test plan
- Reset, then read addr 5 with SA_OUT=32'hA5A5_0F0F → PCH in cycles 1–2, WL[5] in cycles 3–5, SAEN in cycle 5; rd_valid_o pulses in cycle 6 with rd_data_o=32'hA5A5_0F0F; rd_data_o is held afterward.
- Write addr 127, data 32'hDEAD_BEEF → WRITE and WL[127] in cycles 3–4, WR_DATA=32'hDEAD_BEEF, no rd_valid_o pulse, ready returns in cycle 5.
- Hold rq_valid_i high with changing addr_i during a busy read → only the first address appears on WL; the second request is accepted on the cycle rd_valid_o=1.
- Assert rst in cycle 3 of a write → all analog controls are 0 next cycle, rq_ready_o=1, rd_data_o=0.
- Parameters pchCycles=1, wlCycles=1, saenCycles=3 → read latency 6; SAEN high for exactly 3 cycles.
- Random read/write stream checked against a reference memory model → every rd_data_o matches; at most one WL bit high; PCH and WL are never high together.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// ============================================================================
// Module      : sram_access_ctrl
// Description : Single-word SRAM request responder that sequences the analog
//               macro controls: precharge, wordline, write, and sense.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_access_ctrl #(
    parameter int numRows    = 128,
    parameter int numCols    = 32,
    parameter int pchCycles  = 2,
    parameter int wlCycles   = 2,
    parameter int saenCycles = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rq_valid_i,
    input  logic                       rq_wr_i,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    output logic                       rq_ready_o,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    output logic [numRows-1:0]         WL,
    output logic                       PCH,
    output logic                       WRITE,
    output logic [numCols-1:0]         WR_DATA,
    output logic [numCols-1:0]         CSEL,
    output logic                       SAEN,
    input  logic [numCols-1:0]         SA_OUT
);

    localparam int c_aw        = $clog2(numRows);
    localparam int c_max_a     = (pchCycles > wlCycles) ? pchCycles : wlCycles;
    localparam int c_cnt_max   = (c_max_a > saenCycles) ? c_max_a : saenCycles;
    localparam int c_cnt_w     = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_pch_load  = c_cnt_w'(pchCycles - 1);
    localparam logic [c_cnt_w-1:0] c_wl_load   = c_cnt_w'(wlCycles - 1);
    localparam logic [c_cnt_w-1:0] c_saen_load = c_cnt_w'(saenCycles - 1);

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_precharge = 3'd1;
    localparam logic [2:0] c_wordline  = 3'd2;
    localparam logic [2:0] c_sense     = 3'd3;
    localparam logic [2:0] c_done      = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_aw-1:0]    r_addr;
    logic               r_wr;

    logic               w_accept;
    logic [c_aw-1:0]    w_addr_nxt;
    logic               w_wr_nxt;
    logic [numCols-1:0] w_wr_data_nxt;
    logic [numRows-1:0] w_wl_nxt;
    logic               w_pch_nxt;
    logic               w_write_nxt;
    logic [numCols-1:0] w_csel_nxt;
    logic               w_saen_nxt;
    logic               w_ready_nxt;
    logic               w_rd_valid_nxt;
    logic               w_capture;

    assign w_accept  = ((r_state == c_idle) || (r_state == c_done)) && rq_valid_i;
    assign w_capture = (r_state == c_sense) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            rq_ready_o <= 1'b1;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            WL         <= '0;
            PCH        <= 1'b0;
            WRITE      <= 1'b0;
            WR_DATA    <= '0;
            CSEL       <= '0;
            SAEN       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_wr       <= w_wr_nxt;
            rq_ready_o <= w_ready_nxt;
            rd_valid_o <= w_rd_valid_nxt;
            WL         <= w_wl_nxt;
            PCH        <= w_pch_nxt;
            WRITE      <= w_write_nxt;
            WR_DATA    <= w_wr_data_nxt;
            CSEL       <= w_csel_nxt;
            SAEN       <= w_saen_nxt;
            if (w_capture) begin
                rd_data_o <= SA_OUT;
            end
        end
    end

    // The counter is reloaded with (duration-1) on every state entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - 1'b1;
        case (r_state)
            c_idle, c_done: begin
                w_cnt_nxt = '0;
                if (rq_valid_i) begin
                    w_state_nxt = c_precharge;
                    w_cnt_nxt   = c_pch_load;
                end else begin
                    w_state_nxt = c_idle;
                end
            end
            c_precharge: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_wordline;
                    w_cnt_nxt   = c_wl_load;
                end
            end
            c_wordline: begin
                if (r_cnt == '0) begin
                    if (r_wr) begin
                        w_state_nxt = c_idle;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = c_sense;
                        w_cnt_nxt   = c_saen_load;
                    end
                end
            end
            c_sense: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_done;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered controls line
    // up with the state they belong to.
    always_comb begin
        w_addr_nxt     = w_accept ? addr_i : r_addr;
        w_wr_nxt       = w_accept ? rq_wr_i : r_wr;
        w_wr_data_nxt  = (w_accept && rq_wr_i) ? wr_data_i : WR_DATA;
        w_wl_nxt       = '0;
        if ((w_state_nxt == c_wordline) || (w_state_nxt == c_sense)) begin
            w_wl_nxt[w_addr_nxt] = 1'b1;
        end
        w_pch_nxt      = (w_state_nxt == c_precharge);
        w_write_nxt    = (w_state_nxt == c_wordline) && w_wr_nxt;
        w_csel_nxt     = ((w_state_nxt == c_precharge) || (w_state_nxt == c_wordline) ||
                          (w_state_nxt == c_sense)) ? '1 : '0;
        w_saen_nxt     = (w_state_nxt == c_sense);
        w_ready_nxt    = (w_state_nxt == c_idle) || (w_state_nxt == c_done);
        w_rd_valid_nxt = (w_state_nxt == c_done);
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
// ============================================================================
// Module      : tb_sram_access_ctrl
// Description : Directed and random-stream bench for sram_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_access_ctrl;

    localparam int ROWS = 128;
    localparam int COLS = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rq_valid = 1'b0;
    logic             rq_wr = 1'b0;
    logic [6:0]       addr = '0;
    logic [COLS-1:0]  wdata = '0;
    logic             rq_ready;
    logic             rd_valid;
    logic [COLS-1:0]  rd_data;
    logic [ROWS-1:0]  wl;
    logic             pch;
    logic             write;
    logic [COLS-1:0]  wr_data;
    logic [COLS-1:0]  csel;
    logic             saen;
    logic [COLS-1:0]  sa_out;
    logic [COLS-1:0]  sa_drive = '0;
    logic [COLS-1:0]  model_out;
    logic             use_model = 1'b0;
    logic             mem_clr = 1'b0;

    logic             b_valid = 1'b0;
    logic [6:0]       b_addr = '0;
    logic [COLS-1:0]  b_sa = '0;
    logic             b_ready, b_rdv, b_pch, b_write, b_saen;
    logic [COLS-1:0]  b_rdata, b_wrd, b_csel;
    logic [ROWS-1:0]  b_wl;

    logic [COLS-1:0]  sram [ROWS];
    logic [COLS-1:0]  ref_mem [ROWS];

    int total = 0;
    int bad = 0;
    int n;
    int saen_cnt;
    logic             op_wr;
    logic [6:0]       op_a;
    logic [COLS-1:0]  op_d;
    logic [ROWS-1:0]  exp_wl;

    always #5 clk = ~clk;

    sram_access_ctrl #(
        .numRows(ROWS), .numCols(COLS), .pchCycles(2), .wlCycles(2), .saenCycles(1)
    ) dut (
        .clk(clk), .rst(rst), .rq_valid_i(rq_valid), .rq_wr_i(rq_wr), .addr_i(addr),
        .wr_data_i(wdata), .rq_ready_o(rq_ready), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .WL(wl), .PCH(pch), .WRITE(write), .WR_DATA(wr_data), .CSEL(csel), .SAEN(saen),
        .SA_OUT(sa_out)
    );

    sram_access_ctrl #(
        .numRows(ROWS), .numCols(COLS), .pchCycles(1), .wlCycles(1), .saenCycles(3)
    ) dut2 (
        .clk(clk), .rst(rst), .rq_valid_i(b_valid), .rq_wr_i(1'b0), .addr_i(b_addr),
        .wr_data_i('0), .rq_ready_o(b_ready), .rd_valid_o(b_rdv), .rd_data_o(b_rdata),
        .WL(b_wl), .PCH(b_pch), .WRITE(b_write), .WR_DATA(b_wrd), .CSEL(b_csel), .SAEN(b_saen),
        .SA_OUT(b_sa)
    );

    // Behavioural SRAM array driven by the controller's analog controls.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int r = 0; r < ROWS; r++) sram[r] <= '0;
        end else if (write) begin
            for (int r = 0; r < ROWS; r++) if (wl[r]) sram[r] <= wr_data;
        end
    end

    always_comb begin
        model_out = '0;
        for (int r = 0; r < ROWS; r++) if (wl[r]) model_out = sram[r];
    end

    assign sa_out = use_model ? model_out : sa_drive;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("wl_onehot0", {127'b0, $onehot0(wl)}, 128'd1);
        check("pch_wl_excl", {127'b0, pch & (|wl)}, 128'd0);
    endtask

    initial begin
        // Reset, with a request pending that must not be accepted.
        rst = 1'b1; rq_valid = 1'b1; addr = 7'd1;
        tick(); tick();
        check("rst_ready", {127'b0, rq_ready}, 128'd1);
        check("rst_rd_valid", {127'b0, rd_valid}, 128'd0);
        check("rst_rd_data", {96'b0, rd_data}, 128'd0);
        check("rst_wl", wl, 128'd0);
        check("rst_pch", {127'b0, pch}, 128'd0);
        check("rst_write", {127'b0, write}, 128'd0);
        check("rst_wr_data", {96'b0, wr_data}, 128'd0);
        check("rst_csel", {96'b0, csel}, 128'd0);
        check("rst_saen", {127'b0, saen}, 128'd0);
        rst = 1'b0; rq_valid = 1'b0;
        tick();
        check("no_accept_in_rst", {127'b0, pch}, 128'd0);

        // Read addr 5.
        rq_valid = 1'b1; rq_wr = 1'b0; addr = 7'd5; sa_drive = 32'hA5A5_0F0F;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) rq_valid = 1'b0;
            exp_wl = (c >= 3 && c <= 5) ? (128'd1 << 5) : '0;
            check("rd_pch", {127'b0, pch}, {127'b0, (c <= 2)});
            check("rd_wl", wl, exp_wl);
            check("rd_saen", {127'b0, saen}, {127'b0, (c == 5)});
            check("rd_csel", {96'b0, csel}, (c <= 5) ? 128'hFFFF_FFFF : 128'd0);
            check("rd_valid", {127'b0, rd_valid}, {127'b0, (c == 6)});
            check("rd_ready", {127'b0, rq_ready}, {127'b0, (c >= 6)});
            if (c >= 6) check("rd_data", {96'b0, rd_data}, 128'hA5A5_0F0F);
            if (c == 6) sa_drive = 32'h0;
        end

        // Write addr 127.
        rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd127; wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin rq_valid = 1'b0; wdata = 32'h0; addr = 7'd0; end
            exp_wl = (c == 3 || c == 4) ? (128'd1 << 127) : '0;
            check("wr_pch", {127'b0, pch}, {127'b0, (c <= 2)});
            check("wr_wl", wl, exp_wl);
            check("wr_write", {127'b0, write}, {127'b0, (c == 3 || c == 4)});
            check("wr_data_out", {96'b0, wr_data}, 128'hDEAD_BEEF);
            check("wr_no_rdv", {127'b0, rd_valid}, 128'd0);
            check("wr_ready", {127'b0, rq_ready}, {127'b0, (c == 5)});
        end

        // Request held while busy: second address only used after completion.
        rq_valid = 1'b1; rq_wr = 1'b0; addr = 7'd9; sa_drive = 32'h1111_2222;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) addr = 7'd20;
            if (c == 7) rq_valid = 1'b0;
            exp_wl = (c >= 3 && c <= 5) ? (128'd1 << 9) :
                     (c >= 9 && c <= 11) ? (128'd1 << 20) : '0;
            check("busy_wl", wl, exp_wl);
            check("busy_rdv", {127'b0, rd_valid}, {127'b0, (c == 6 || c == 12)});
            if (c == 6) begin
                check("busy_rd0", {96'b0, rd_data}, 128'h1111_2222);
                sa_drive = 32'h3333_4444;
            end
            if (c == 7) check("busy_pch2", {127'b0, pch}, 128'd1);
            if (c == 12) check("busy_rd1", {96'b0, rd_data}, 128'h3333_4444);
        end

        // Reset in cycle 3 of a write.
        rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd3; wdata = 32'h1234_5678;
        tick(); rq_valid = 1'b0;
        tick(); tick();
        check("mid_write_active", {127'b0, write}, 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_wl", wl, 128'd0);
        check("mrst_pch", {127'b0, pch}, 128'd0);
        check("mrst_write", {127'b0, write}, 128'd0);
        check("mrst_saen", {127'b0, saen}, 128'd0);
        check("mrst_csel", {96'b0, csel}, 128'd0);
        check("mrst_wr_data", {96'b0, wr_data}, 128'd0);
        check("mrst_ready", {127'b0, rq_ready}, 128'd1);
        check("mrst_rd_data", {96'b0, rd_data}, 128'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mrst_no_rdv", {127'b0, rd_valid}, 128'd0);
            check("mrst_idle", {127'b0, rq_ready}, 128'd1);
        end

        // Short precharge/wordline, long sense.
        b_valid = 1'b1; b_addr = 7'd7; b_sa = 32'hCAFE_0001; saen_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) b_valid = 1'b0;
            saen_cnt += int'(b_saen);
            exp_wl = (c >= 2 && c <= 5) ? (128'd1 << 7) : '0;
            check("p2_pch", {127'b0, b_pch}, {127'b0, (c == 1)});
            check("p2_wl", b_wl, exp_wl);
            check("p2_saen", {127'b0, b_saen}, {127'b0, (c >= 3 && c <= 5)});
            check("p2_rdv", {127'b0, b_rdv}, {127'b0, (c == 6)});
        end
        check("p2_saen_cycles", 128'(saen_cnt), 128'd3);
        check("p2_rd_data", {96'b0, b_rdata}, 128'hCAFE_0001);

        // Random read/write stream against a reference memory.
        use_model = 1'b1; mem_clr = 1'b1;
        for (int r = 0; r < ROWS; r++) ref_mem[r] = '0;
        tick();
        mem_clr = 1'b0;
        for (int k = 0; k < 30; k++) begin
            op_wr = 1'($urandom_range(0, 1));
            op_a = 7'($urandom_range(0, 7));
            op_d = $urandom;
            rq_valid = 1'b1; rq_wr = op_wr; addr = op_a; wdata = op_d;
            n = 0;
            while (!rq_ready && n < 20) begin tick(); n++; end
            tick();
            rq_valid = 1'b0;
            n = 0;
            if (op_wr) begin
                ref_mem[op_a] = op_d;
                while (!rq_ready && n < 20) begin tick(); n++; end
                check("rnd_wr_done", {127'b0, rq_ready}, 128'd1);
            end else begin
                while (!rd_valid && n < 20) begin tick(); n++; end
                check("rnd_rd_valid", {127'b0, rd_valid}, 128'd1);
                check("rnd_rd_data", {96'b0, rd_data}, {96'b0, ref_mem[op_a]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
